neuromorphic_x1_arbiter: RTL and testbench

- Two-requester scheduler in front of the NEUROMORPHIC_X1 ReRAM macro.
- Arbitrates host and inference-engine requests onto the macro's single EN/R_WB/DI/func_ack port, and packs row/col/data into the macro's write word.
- Holds EN until the macro acknowledges, tracks macro queue occupancy, rejects impossible operations locally, and enforces a timeout.
- Sits between the Wishbone slave glue and the macro.

---
 rtl/neuromorphic_x1_arbiter_pkg.sv | 30 +++
 rtl/neuromorphic_x1_arbiter_if.sv | 41 ++++
 rtl/neuromorphic_x1_rr_arb.sv | 25 ++
 rtl/neuromorphic_x1_arbiter.sv | 176 +++++++++++++++++
 tb/tb_neuromorphic_x1_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/neuromorphic_x1_arbiter_pkg.sv
// Shared types, DI field layout and the DI packing helper for the NEUROMORPHIC_X1 arbiter.
package neuromorphic_x1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_REJECT = 2'd2,
    ST_GAP    = 2'd3
  } arb_state_t;

  localparam int ROW_MSB   = 29;
  localparam int ROW_LSB   = 25;
  localparam int COL_MSB   = 24;
  localparam int COL_LSB   = 20;
  localparam int DATA_W    = 8;
  localparam int DEPTH_DEF = 32;

  // Macro write word: row in [29:25], col in [24:20], data in [7:0], rest zero.
  function automatic logic [31:0] pack_di(input logic [4:0] row,
                                          input logic [4:0] col,
                                          input logic [DATA_W-1:0] data);
    logic [31:0] w;
    w = '0;
    w[ROW_MSB:ROW_LSB] = row;
    w[COL_MSB:COL_LSB] = col;
    w[DATA_W-1:0]      = data;
    return w;
  endfunction

endpackage

// File: rtl/neuromorphic_x1_arbiter_if.sv
// Requester, macro and status signals of the arbiter; slave = arbiter side, master = environment.
interface neuromorphic_x1_arbiter_if;
  import neuromorphic_x1_pkg::*;

  // Requester handshake: req is a level held until the one-cycle ack or err pulse
  // for that requester; rdata is valid with a read ack and held until the next read.
  logic [1:0]  req;
  logic [1:0]  we;
  logic [9:0]  row;
  logic [9:0]  col;
  logic [15:0] wdata;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [7:0]  rdata;

  logic        mac_en;
  logic        mac_r_wb;
  logic [31:0] mac_di;
  logic [31:0] mac_ad;
  logic [3:0]  mac_sel;
  logic [31:0] mac_do;
  logic        mac_ack;

  logic [5:0]  occupancy;
  logic        busy;
  logic        gnt_id;
  arb_state_t  dbg_state;

  modport slave (
    input  req, we, row, col, wdata, mac_do, mac_ack,
    output ack, err, rdata, mac_en, mac_r_wb, mac_di, mac_ad, mac_sel,
           occupancy, busy, gnt_id, dbg_state
  );

  modport master (
    output req, we, row, col, wdata, mac_do, mac_ack,
    input  ack, err, rdata, mac_en, mac_r_wb, mac_di, mac_ad, mac_sel,
           occupancy, busy, gnt_id, dbg_state
  );

endinterface

// File: rtl/neuromorphic_x1_rr_arb.sv
// Two-way round-robin: combinational grant, pointer moves to the loser when upd_i strobes.
module neuromorphic_x1_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       upd_i,
  output logic       gnt_o,
  output logic       valid_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    valid_o = |req_i;
    gnt_o   = (req_i == 2'b11) ? ptr_q : req_i[1];
    ptr_d   = ptr_q;
    if (upd_i && valid_o) ptr_d = ~gnt_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/neuromorphic_x1_arbiter.sv
// Schedules host / inference requests onto the single NEUROMORPHIC_X1 macro port,
// tracking macro queue occupancy, rejecting impossible operations and timing out stalls.
module neuromorphic_x1_arbiter
  import neuromorphic_x1_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int TIMEOUT_CYC = 2048,
  parameter int GAP_CYC     = 1
) (
  input  logic                      CLKin,
  input  logic                      RSTin,
  neuromorphic_x1_arbiter_if.slave  bus
);

  localparam int TO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  arb_state_t       state_q, state_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [31:0]      di_q, di_d;
  logic             en_q, en_d;
  logic             rwb_q, rwb_d;
  logic [3:0]       sel_q, sel_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [5:0]       occ_q, occ_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

  logic       arb_gnt, arb_valid, arb_upd;
  logic       w_we;
  logic [4:0] w_row, w_col;
  logic [7:0] w_data;
  logic       unused_do;

  assign arb_upd   = (state_q == ST_IDLE);
  assign unused_do = ^bus.mac_do[31:DATA_W];

  neuromorphic_x1_rr_arb u_rr (
    .clk_i   (CLKin),
    .rst_i   (RSTin),
    .req_i   (bus.req),
    .upd_i   (arb_upd),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  always_comb begin
    w_we   = bus.we[arb_gnt];
    w_row  = arb_gnt ? bus.row[9:5]    : bus.row[4:0];
    w_col  = arb_gnt ? bus.col[9:5]    : bus.col[4:0];
    w_data = arb_gnt ? bus.wdata[15:8] : bus.wdata[7:0];
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    we_d      = we_q;
    di_d      = di_q;
    en_d      = en_q;
    rwb_d     = rwb_q;
    sel_d     = sel_q;
    ack_d     = 2'b00;
    err_d     = 2'b00;
    rdata_d   = rdata_q;
    occ_d     = occ_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_d    = arb_gnt;
          we_d     = w_we;
          di_d     = pack_di(w_row, w_col, w_data);
          to_cnt_d = '0;
          if ((w_we && occ_q == 6'(DEPTH)) || (!w_we && occ_q == 6'd0)) begin
            state_d = ST_REJECT;
          end else begin
            state_d = ST_ISSUE;
            en_d    = 1'b1;
            rwb_d   = ~w_we;
            sel_d   = 4'hF;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.mac_ack) begin
          en_d      = 1'b0;
          rwb_d     = 1'b0;
          sel_d     = 4'h0;
          ack_d     = gnt_q ? 2'b10 : 2'b01;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
          if (!we_q) begin
            rdata_d = bus.mac_do[DATA_W-1:0];
            if (occ_q != 6'd0) occ_d = occ_q - 6'd1;
          end else if (occ_q != 6'(DEPTH)) begin
            occ_d = occ_q + 6'd1;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          // Abort: the macro state is unknown, so occupancy is left as it was.
          en_d      = 1'b0;
          rwb_d     = 1'b0;
          sel_d     = 4'h0;
          err_d     = gnt_q ? 2'b10 : 2'b01;
          gap_cnt_d = '0;
          state_d   = ST_GAP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_REJECT: begin
        err_d   = gnt_q ? 2'b10 : 2'b01;
        state_d = ST_IDLE;
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYC - 1)) state_d = ST_IDLE;
        else                                  gap_cnt_d = gap_cnt_q + 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      we_q      <= 1'b0;
      di_q      <= '0;
      en_q      <= 1'b0;
      rwb_q     <= 1'b0;
      sel_q     <= 4'h0;
      ack_q     <= 2'b00;
      err_q     <= 2'b00;
      rdata_q   <= 8'h00;
      occ_q     <= 6'd0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      di_q      <= di_d;
      en_q      <= en_d;
      rwb_q     <= rwb_d;
      sel_q     <= sel_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
      occ_q     <= occ_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mac_en    = en_q;
  assign bus.mac_r_wb  = rwb_q;
  assign bus.mac_di    = di_q;
  assign bus.mac_ad    = di_q;
  assign bus.mac_sel   = sel_q;
  assign bus.occupancy = occ_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.gnt_id    = gnt_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_neuromorphic_x1_arbiter.sv
// Directed bench for neuromorphic_x1_arbiter with a behavioural macro (write ack 1 cycle, read 44).
module tb_neuromorphic_x1_arbiter;
  import neuromorphic_x1_pkg::*;

  logic CLKin;
  logic RSTin;
  int   n_tests = 0;
  int   n_fail  = 0;

  neuromorphic_x1_arbiter_if bus ();

  neuromorphic_x1_arbiter #(.DEPTH(32), .TIMEOUT_CYC(2048), .GAP_CYC(1)) dut (
    .CLKin (CLKin),
    .RSTin (RSTin),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLKin = 1'b0;
    forever #5 CLKin = ~CLKin;
  end

  // ---------------- macro model ----------------
  logic [7:0] mem [0:1023];
  int         m_cnt;
  logic       m_dead;

  always @(posedge CLKin or posedge RSTin) begin
    if (RSTin) begin
      bus.mac_ack <= 1'b0;
      bus.mac_do  <= 32'h0;
      m_cnt       <= 0;
    end else begin
      bus.mac_ack <= 1'b0;
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) bus.mac_ack <= 1'b1;
      end else if (bus.mac_en && !bus.mac_ack && !m_dead) begin
        if (bus.mac_r_wb) begin
          bus.mac_do <= {24'h0, mem[{bus.mac_di[29:25], bus.mac_di[24:20]}]};
          m_cnt      <= 44;
        end else begin
          mem[{bus.mac_di[29:25], bus.mac_di[24:20]}] <= bus.mac_di[7:0];
          bus.mac_ack <= 1'b1;
        end
      end
    end
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RSTin = 1'b1;
    repeat (2) @(posedge CLKin);
    @(negedge CLKin);
    RSTin = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Edge 1 is the grant edge; lat is the edge after which the response pulse is visible.
  task automatic run_txn(input int id, input logic w, input logic [4:0] r, input logic [4:0] c,
                         input logic [7:0] d, input int budget,
                         output int lat, output logic [1:0] resp, output logic is_err,
                         output logic en_seen, output logic [31:0] di1, output logic rwb1,
                         output logic gnt1, output logic en_at_resp);
    @(negedge CLKin);
    bus.we[id] = w;
    if (id == 0) begin
      bus.row[4:0] = r; bus.col[4:0] = c; bus.wdata[7:0] = d;
    end else begin
      bus.row[9:5] = r; bus.col[9:5] = c; bus.wdata[15:8] = d;
    end
    bus.req = (id == 0) ? 2'b01 : 2'b10;
    lat = 0; resp = 2'b00; is_err = 1'b0; en_seen = 1'b0;
    di1 = '0; rwb1 = 1'b0; gnt1 = 1'b0; en_at_resp = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge CLKin);
      @(negedge CLKin);
      if (k == 1) begin
        di1 = bus.mac_di; rwb1 = bus.mac_r_wb; gnt1 = bus.gnt_id;
      end
      if (bus.mac_en) en_seen = 1'b1;
      if (bus.ack != 2'b00 || bus.err != 2'b00) begin
        lat = k; resp = bus.ack | bus.err; is_err = |bus.err; en_at_resp = bus.mac_en;
        break;
      end
    end
    bus.req = 2'b00;
  endtask

  // ---------------- stimulus ----------------
  int          lat;
  logic [1:0]  resp;
  logic        is_err, en_seen, rwb1, gnt1, en_at_resp;
  logic [31:0] di1;
  int          n_acks, low_cnt, ack_ids[4], bad_wr, resp_seen;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    m_dead    = 1'b0;
    bus.req   = 2'b00;
    bus.we    = 2'b00;
    bus.row   = '0;
    bus.col   = '0;
    bus.wdata = '0;
    do_reset();

    // Reset state
    chk("rst_ack", {30'h0, bus.ack}, 32'h0);
    chk("rst_err", {30'h0, bus.err}, 32'h0);
    chk("rst_en", {31'h0, bus.mac_en}, 32'h0);
    chk("rst_occ", {26'h0, bus.occupancy}, 32'h0);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_di", bus.mac_di, 32'h0);

    // Requester 0 write row 3 / col 7 / 0xA5
    run_txn(0, 1'b1, 5'd3, 5'd7, 8'hA5, 100, lat, resp, is_err, en_seen, di1, rwb1, gnt1, en_at_resp);
    chk("wr_di", di1, 32'h067000A5);
    chk("wr_rwb", {31'h0, rwb1}, 32'h0);
    chk("wr_gnt", {31'h0, gnt1}, 32'h0);
    chk("wr_lat", lat, 3);
    chk("wr_resp", {30'h0, resp}, 32'h1);
    chk("wr_is_err", {31'h0, is_err}, 32'h0);
    chk("wr_occ", {26'h0, bus.occupancy}, 32'd1);

    // Requester 1 reads it back
    run_txn(1, 1'b0, 5'd3, 5'd7, 8'h00, 200, lat, resp, is_err, en_seen, di1, rwb1, gnt1, en_at_resp);
    chk("rd_rwb", {31'h0, rwb1}, 32'h1);
    chk("rd_gnt", {31'h0, gnt1}, 32'h1);
    chk("rd_di", di1, 32'h06700000);
    chk("rd_lat", lat, 47);
    chk("rd_resp", {30'h0, resp}, 32'h2);
    chk("rd_data", {24'h0, bus.rdata}, 32'hA5);
    chk("rd_occ", {26'h0, bus.occupancy}, 32'd0);

    // Read with empty queue is rejected locally
    run_txn(0, 1'b0, 5'd1, 5'd1, 8'h00, 100, lat, resp, is_err, en_seen, di1, rwb1, gnt1, en_at_resp);
    chk("rej_rd_lat", lat, 2);
    chk("rej_rd_err", {30'h0, bus.err | resp}, 32'h1);
    chk("rej_rd_is_err", {31'h0, is_err}, 32'h1);
    chk("rej_rd_en", {31'h0, en_seen}, 32'h0);
    chk("rej_rd_occ", {26'h0, bus.occupancy}, 32'd0);

    // Both requesters held, all writes: grants alternate with a gap between them
    do_reset();
    @(negedge CLKin);
    bus.we = 2'b11; bus.row = {5'd2, 5'd1}; bus.col = {5'd4, 5'd3}; bus.wdata = 16'h3C5A;
    bus.req = 2'b11;
    n_acks = 0; low_cnt = 0;
    for (int k = 0; k < 200 && n_acks < 4; k++) begin
      @(posedge CLKin);
      @(negedge CLKin);
      if (bus.ack != 2'b00) begin
        ack_ids[n_acks] = int'(bus.ack[1]);
        if (n_acks > 0) chk("alt_gap_low", {31'h0, low_cnt >= 1}, 32'h1);
        n_acks++;
        low_cnt = 0;
      end else if (!bus.mac_en) begin
        low_cnt++;
      end
    end
    bus.req = 2'b00;
    chk("alt_count", n_acks, 4);
    chk("alt_id0", ack_ids[0], 0);
    chk("alt_id1", ack_ids[1], 1);
    chk("alt_id2", ack_ids[2], 0);
    chk("alt_id3", ack_ids[3], 1);
    chk("alt_occ", {26'h0, bus.occupancy}, 32'd4);

    // Fill to DEPTH, then one more write must be rejected
    bad_wr = 0;
    for (int i = 0; i < 28; i++) begin
      run_txn(0, 1'b1, 5'(i), 5'd9, 8'(i + 1), 100, lat, resp, is_err, en_seen, di1, rwb1, gnt1, en_at_resp);
      if (lat != 3 || resp != 2'b01) bad_wr++;
    end
    chk("fill_bad", bad_wr, 0);
    chk("fill_occ", {26'h0, bus.occupancy}, 32'd32);
    run_txn(0, 1'b1, 5'd30, 5'd30, 8'h77, 100, lat, resp, is_err, en_seen, di1, rwb1, gnt1, en_at_resp);
    chk("full_lat", lat, 2);
    chk("full_is_err", {31'h0, is_err}, 32'h1);
    chk("full_en", {31'h0, en_seen}, 32'h0);
    chk("full_occ", {26'h0, bus.occupancy}, 32'd32);

    // Dead macro: timeout after 2048 ISSUE cycles
    m_dead = 1'b1;
    run_txn(0, 1'b0, 5'd3, 5'd7, 8'h00, 2200, lat, resp, is_err, en_seen, di1, rwb1, gnt1, en_at_resp);
    m_dead = 1'b0;
    chk("to_lat", lat, 2049);
    chk("to_resp", {30'h0, resp}, 32'h1);
    chk("to_is_err", {31'h0, is_err}, 32'h1);
    chk("to_en", {31'h0, en_at_resp}, 32'h0);
    chk("to_occ", {26'h0, bus.occupancy}, 32'd32);

    // Reset during a pending read
    @(negedge CLKin);
    bus.we = 2'b00; bus.row = {5'd3, 5'd0}; bus.col = {5'd7, 5'd0};
    bus.req = 2'b10;
    repeat (10) @(posedge CLKin);
    chk("pend_en", {31'h0, bus.mac_en}, 32'h1);
    #3 RSTin = 1'b1;
    #1;
    chk("arst_outs", {bus.ack, bus.err, bus.mac_en, bus.mac_r_wb, bus.busy, bus.gnt_id, bus.mac_sel}, 32'h0);
    chk("arst_di", bus.mac_di, 32'h0);
    chk("arst_rdata_occ", {bus.rdata, 2'b00, bus.occupancy}, 32'h0);
    bus.req = 2'b00;
    @(negedge CLKin);
    RSTin = 1'b0;
    resp_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge CLKin);
      @(negedge CLKin);
      if (bus.ack != 2'b00 || bus.err != 2'b00) resp_seen++;
    end
    chk("arst_no_resp", resp_seen, 0);
    chk("arst_idle", {31'h0, bus.busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
